// File: rtl/limn2600_cache_refill_if.sv
// Bus bundle for the Limn2600 cache refill controller: the CPU load/store
// channel, the memory request/refill channel and the flush request.
// "slave" is the controller's view and "master" is the CPU-plus-memory side.
interface limn2600_cache_refill_if;
    logic        flush;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;

    modport slave (
        input  flush, cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
               mem_req_ready, mem_rdata_valid, mem_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport master (
        output flush, cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
               mem_req_ready, mem_rdata_valid, mem_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/limn2600_cache_refill.sv
// Direct-mapped, write-through, read-allocate cache controller.
// Loads that miss refill the whole line with a burst read; every store is
// forwarded to memory as a single-word write and updates the line only on a hit.
// Line data and tags live in RAM arrays with a registered read port; only the
// valid bits are reset.
module limn2600_cache_refill #(
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    limn2600_cache_refill_if.slave       bus
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 32 - 2 - OB - IB;
    localparam logic [OB-1:0] LAST_BEAT = OB'(LINE_WORDS - 1);
    localparam logic [IB-1:0] LAST_SET  = IB'(SETS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_DATA,
        S_WRITE_REQ,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [OB-1:0]   beat_q, beat_d;
    logic [IB-1:0]   flush_idx_q, flush_idx_d;
    logic [SETS-1:0] valid_q, valid_d;

    // Line storage and tags; contents are never reset
    logic [31:0]     data_mem [SETS*LINE_WORDS];
    logic [TB-1:0]   tag_mem  [SETS];
    logic [31:0]     data_rdata;
    logic [TB-1:0]   tag_rdata;
    logic            data_we;
    logic [IB+OB-1:0] data_waddr;
    logic [31:0]     data_wdata;
    logic            tag_we;

    // Fields of the latched request
    logic [OB-1:0]   req_off;
    logic [IB-1:0]   req_idx;
    logic [TB-1:0]   req_tag;
    logic            hit;
    logic [1:0]      unused_addr_bits;

    assign req_off = addr_q[2+OB-1:2];
    assign req_idx = addr_q[2+OB+IB-1:2+OB];
    assign req_tag = addr_q[31:2+OB+IB];
    assign hit     = valid_q[req_idx] && (tag_rdata == req_tag);
    assign unused_addr_bits = addr_q[1:0];

    // Output values computed by the FSM
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;

    assign bus.cpu_req_ready  = cpu_req_ready;
    assign bus.cpu_resp_valid = cpu_resp_valid;
    assign bus.cpu_resp_rdata = cpu_resp_rdata;
    assign bus.mem_req_valid  = mem_req_valid;
    assign bus.mem_req_we     = mem_req_we;
    assign bus.mem_req_addr   = mem_req_addr;
    assign bus.mem_req_wdata  = mem_req_wdata;

    // RAM ports: the read address is the incoming CPU address, so the word and
    // tag of an accepted request are ready in LOOKUP
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_waddr] <= data_wdata;
        end
        if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
        end
        data_rdata <= data_mem[bus.cpu_req_addr[2+OB+IB-1:2]];
        tag_rdata  <= tag_mem[bus.cpu_req_addr[2+OB+IB-1:2+OB]];
    end

    // Controller state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            beat_q      <= '0;
            flush_idx_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            beat_q      <= beat_d;
            flush_idx_q <= flush_idx_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state, RAM write controls and bus outputs
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        beat_d         = beat_q;
        flush_idx_d    = flush_idx_q;
        valid_d        = valid_q;
        data_we        = 1'b0;
        data_waddr     = {req_idx, req_off};
        data_wdata     = wdata_q;
        tag_we         = 1'b0;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    // Flush beats a simultaneous request, which stays unaccepted
                    flush_idx_d = '0;
                    state_d     = S_FLUSH;
                end else begin
                    // Held low while reset is asserted
                    cpu_req_ready = rst;
                    if (bus.cpu_req_valid) begin
                        we_d    = bus.cpu_req_we;
                        addr_d  = bus.cpu_req_addr;
                        wdata_d = bus.cpu_req_wdata;
                        state_d = S_LOOKUP;
                    end
                end
            end

            S_LOOKUP: begin
                if (we_q) begin
                    // Write-through: update the line only if present, never allocate
                    data_we = hit;
                    state_d = S_WRITE_REQ;
                end else if (hit) begin
                    rdata_d = data_rdata;
                    state_d = S_RESP;
                end else begin
                    // The line is being replaced; it is invalid until the last beat
                    valid_d[req_idx] = 1'b0;
                    beat_d           = '0;
                    state_d          = S_REFILL_REQ;
                end
            end

            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {addr_q[31:2+OB], {(OB+2){1'b0}}};
                if (bus.mem_req_ready) begin
                    beat_d  = '0;
                    state_d = S_REFILL_DATA;
                end
            end

            S_REFILL_DATA: begin
                if (bus.mem_rdata_valid) begin
                    data_we    = 1'b1;
                    data_waddr = {req_idx, beat_q};
                    data_wdata = bus.mem_rdata;
                    beat_d     = beat_q + 1'b1;
                    if (beat_q == req_off) begin
                        rdata_d = bus.mem_rdata;
                    end
                    if (beat_q == LAST_BEAT) begin
                        valid_d[req_idx] = 1'b1;
                        tag_we           = 1'b1;
                        state_d          = S_RESP;
                    end
                end
            end

            S_WRITE_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {addr_q[31:2], 2'b00};
                mem_req_wdata = wdata_q;
                if (bus.mem_req_ready) begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_rdata = we_q ? 32'h0 : rdata_q;
                state_d        = S_IDLE;
            end

            S_FLUSH: begin
                valid_d[flush_idx_q] = 1'b0;
                flush_idx_d          = flush_idx_q + 1'b1;
                if (flush_idx_q == LAST_SET) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
